mem_dma: RTL and testbench
==========================

# mem_dma

Single-channel copy/fill engine that acts as the initiator on the main memory port. It drives read address, write address, write data and write enable, and consumes the combinational read data. It sits beside the CPU datapath and moves blocks of 32-bit words. On a `start` pulse it copies `length` words from `src_addr` to `dst_addr`, or fills `length` words at `dst_addr` with a constant. It runs at one word per cycle and raises a one-cycle `done` pulse when finished.

## Interface
- `LEN_WIDTH`, default 12: width of `length` and `words_copied`. The maximum transfer is 2^LEN_WIDTH-1 words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; latched at start.
- `src_addr`  in  32  source word address; latched at start.
- `dst_addr`  in  32  destination word address; latched at start.
- `length`  in  LEN_WIDTH  word count; latched at start.
- `fill_value`  in  32  fill data; latched at start.
- `busy`  out  1  high while in COPY.
- `done`  out  1  one-cycle completion pulse.
- `words_copied`  out  LEN_WIDTH  number of writes issued for the current or last transfer.
- `mem_read_address`  out  32  to memory read port.
- `mem_read_data`  in  32  combinational read data from memory.
- `mem_write_address`  out  32  to memory write port.
- `mem_write_data`  out  32  to memory write port.
- `mem_write_enable`  out  1  memory write strobe; the memory commits on the same rising edge.

## Operation
- States: IDLE, COPY, DONE.
- IDLE:
  - All memory outputs are 0.
  - `start`=1 with `length`≠0: latch the inputs, clear `words_copied` and the index, and go to COPY.
  - `start`=1 with `length`=0: clear `words_copied` and go to DONE. No write is issued.
- COPY, each cycle:
  - `mem_read_address` = src_reg + idx.
  - `mem_write_address` = dst_reg + idx.
  - `mem_write_enable` = 1.
  - `mem_write_data` = `mem_read_data` in copy mode, fill_reg in fill mode.
  - `words_copied` increments on each edge.
  - Ascending idx runs 0..len-1. When the last word is issued, go to DONE.
- DONE: `done`=1 for exactly one cycle, memory outputs are 0, then go to IDLE.
- `start` in COPY or DONE is ignored and not queued.
- Address arithmetic is 32-bit modulo 2^32; wrap past 0xFFFFFFFF is legal and not flagged.
- In fill mode `mem_read_address` is driven 0.
- Overlap without backward support: reads see all earlier committed writes. If dst_reg > src_reg and dst_reg < src_reg+len, the copy propagates the first (dst-src) source words periodically. This is defined behaviour, not an error.

## Timing
- Reset values: `busy`=0, `done`=0, `words_copied`=0, and all `mem_*` outputs 0. The state is IDLE.
- Start is sampled at edge T0. The first write is visible in the cycle after T0 and commits at edge T1.
- Write k commits at edge T(k+1).
- `done` is high in the cycle after edge Tlen.
- Total latency from start edge to `done` is len+1 cycles. For length=0 it is 1 cycle.
- Throughput is one word per cycle with no stalls.
- Reset asserted mid-transfer takes effect immediately: `mem_write_enable` drops asynchronously, and no `done` is generated. Writes already committed remain in memory.
- `busy` and `done` are never high together.

## Configuration
- `MEM_DMA_BACKWARD_EN` defined:
  - At start, in copy mode, compute the overlap condition dst_addr > src_addr and dst_addr < src_addr + length, using 33-bit unsigned arithmetic.
  - If the condition holds, idx runs descending from len-1 to 0. The result is then a correct memmove.
  - All other cases stay ascending. Cycle count is unchanged.
- Undefined: always ascending, with the overlap behaviour described under Operation.

## Test plan
- Copy, non-overlapping. Preload mem[100..103] = 1,2,3,4; start with src=100, dst=200, len=4, mode=0.
  - Writes go to 200..203 on edges T1..T4 with data 1,2,3,4.
  - `done` pulses in the cycle after T4; `words_copied`=4.
- Fill. Start with dst=50, len=3, mode=1, fill_value=0xDEADBEEF.
  - mem[50..52] = 0xDEADBEEF.
  - `mem_read_address` stays 0 throughout.
- Zero length. Start with len=0.
  - `done` is high in the next cycle.
  - `mem_write_enable` is never asserted; `words_copied`=0.
- Overlap. Preload mem[10..13] = A,B,C,D; copy src=10, dst=11, len=3.
  - Without the macro: mem[11..13] = A,A,A.
  - With `MEM_DMA_BACKWARD_EN`: mem[11..13] = A,B,C, with write addresses 13,12,11 in that order.
- Start while busy and wrap-around.
  - A second `start` during COPY is ignored: no change to addresses or count.
  - Copy src=0xFFFFFFFE, len=3: reads addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Reset mid-transfer. Assert `rst` after 2 of 5 writes.
  - Outputs go to 0 immediately; the state is IDLE and `done` never pulses.
  - A following start with len=1 completes normally.

Source files
------------

// File: rtl/mem_dma.sv
// mem_dma: single-channel copy/fill engine mastering the main memory port.
// Moves one 32-bit word per cycle from src to dst (copy) or writes a
// constant to dst (fill), then pulses done for one cycle.
// Optional feature: define MEM_DMA_BACKWARD_EN to walk overlapping forward
// copies from the top word down, which turns the copy into a true memmove.
module mem_dma #(
  parameter int LEN_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic [31:0]          fill_value,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] words_copied,
  output logic [31:0]          mem_read_address,
  input  logic [31:0]          mem_read_data,
  output logic [31:0]          mem_write_address,
  output logic [31:0]          mem_write_data,
  output logic                 mem_write_enable
);

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DONE
  } state_t;

  state_t state, state_next;

  logic [31:0]          src_reg;
  logic [31:0]          dst_reg;
  logic [31:0]          fill_reg;
  logic                 mode_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] idx;
  logic                 backward_reg;
  logic                 backward_start;
  logic                 last_word;
  logic [31:0]          idx_ext;

`ifdef MEM_DMA_BACKWARD_EN
  // A forward copy whose destination starts inside the source block would
  // overwrite source words before they are read; 33 bits keep the end
  // address comparison exact even when the source block wraps past 2^32.
  logic [32:0] src_end;
  assign src_end = {1'b0, src_addr} + 33'(length);
  assign backward_start = !mode
                          && ({1'b0, dst_addr} > {1'b0, src_addr})
                          && ({1'b0, dst_addr} < src_end);
`else
  assign backward_start = 1'b0;
`endif

  assign idx_ext   = 32'(idx);
  assign last_word = (words_copied == (len_reg - LEN_WIDTH'(1)));

  // State register; reset returns to IDLE at once so the write strobe drops
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and memory port drive; everything is zero outside COPY.
  always_comb begin
    state_next        = state;
    busy              = 1'b0;
    done              = 1'b0;
    mem_read_address  = 32'd0;
    mem_write_address = 32'd0;
    mem_write_data    = 32'd0;
    mem_write_enable  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (length != '0) ? COPY : DONE;
      end
      COPY: begin
        busy              = 1'b1;
        mem_read_address  = mode_reg ? 32'd0 : (src_reg + idx_ext);
        mem_write_address = dst_reg + idx_ext;
        mem_write_data    = mode_reg ? fill_reg : mem_read_data;
        mem_write_enable  = 1'b1;
        if (last_word) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transfer parameters are captured on an accepted start; the index and
  // the write count then advance together once per issued word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_reg      <= 32'd0;
      dst_reg      <= 32'd0;
      fill_reg     <= 32'd0;
      mode_reg     <= 1'b0;
      len_reg      <= '0;
      idx          <= '0;
      backward_reg <= 1'b0;
      words_copied <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            words_copied <= '0;
            idx          <= '0;
            if (length != '0) begin
              src_reg      <= src_addr;
              dst_reg      <= dst_addr;
              fill_reg     <= fill_value;
              mode_reg     <= mode;
              len_reg      <= length;
              backward_reg <= backward_start;
              idx          <= backward_start ? (length - LEN_WIDTH'(1)) : '0;
            end
          end
        end
        COPY: begin
          words_copied <= words_copied + LEN_WIDTH'(1);
          idx          <= backward_reg ? (idx - LEN_WIDTH'(1)) : (idx + LEN_WIDTH'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: randomized and directed transfers against a word-array model
// of memory. Every transfer pushes its expected write stream into a queue;
// a monitor pops and compares whenever the engine writes or signals done.
module tb_mem_dma;

  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic [LW-1:0] length;
  logic [31:0]   fill_value;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_copied;
  logic [31:0]   mem_read_address;
  logic [31:0]   mem_read_data;
  logic [31:0]   mem_write_address;
  logic [31:0]   mem_write_data;
  logic          mem_write_enable;

  mem_dma #(.LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .busy(busy), .done(done),
    .words_copied(words_copied), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable)
  );

  always #5 clk = ~clk;

  // 256-word memory; addresses alias on their low byte so wrap tests fit.
  logic [31:0] mem   [256];
  logic [31:0] model [256];

  assign mem_read_data = mem[mem_read_address[7:0]];

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_write_address[7:0]] <= mem_write_data;
  end

  typedef struct {
    logic [31:0] ra;
    logic [31:0] wa;
    logic [31:0] wd;
    int          wc;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a transfer is a sequence of word moves performed in order on
  // the model memory, ascending unless the backward option applies.
  task automatic modelTransfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                               input int len, input logic [31:0] f, input int maxw);
    bit backward = 0;
    wr_t w;
`ifdef MEM_DMA_BACKWARD_EN
    if (!m && ({1'b0, d} > {1'b0, s}) && ({1'b0, d} < ({1'b0, s} + 33'(len)))) backward = 1;
`endif
    for (int k = 0; k < len && k < maxw; k++) begin
      logic [31:0] i;
      i    = backward ? 32'(len - 1 - k) : 32'(k);
      w.ra = m ? 32'd0 : s + i;
      w.wa = d + i;
      w.wd = m ? f : model[w.ra[7:0]];
      w.wc = k;
      model[w.wa[7:0]] = w.wd;
      exp_wr.push_back(w);
    end
    if (maxw >= len) exp_done.push_back(len);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) checkOutput("busy_and_done", 32'd1, 32'd0);
      if (mem_write_enable) begin
        if (exp_wr.size() == 0) begin
          checkOutput("unexpected_write", mem_write_address, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          checkOutput("read_addr", mem_read_address, w.ra);
          checkOutput("write_addr", mem_write_address, w.wa);
          checkOutput("write_data", mem_write_data, w.wd);
          checkOutput("count_during", 32'(words_copied), 32'(w.wc));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          int c;
          c = exp_done.pop_front();
          checkOutput("words_copied", 32'(words_copied), 32'(c));
        end
      end
    end
  end

  // Issue one transfer from a falling edge and time start-edge to done.
  // With poke set, a conflicting start is raised while the copy runs.
  task automatic applyStimulus(input logic m, input logic [31:0] s, input logic [31:0] d,
                               input int len, input logic [31:0] f, input bit poke);
    int n;
    bit seen;
    modelTransfer(m, s, d, len, f, 1 << 30);
    mode = m; src_addr = s; dst_addr = d; length = LW'(len); fill_value = f;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < len + 10) begin
      @(negedge clk);
      n++;
      if (poke && n == 2) begin
        start = 1'b1; src_addr = 32'h55; dst_addr = 32'hAA; length = LW'(7);
      end
      if (poke && n == 3) start = 1'b0;
      if (done) seen = 1;
    end
    checkOutput("done_latency", 32'(n), 32'(len + 1));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i]   <= v;
      model[i]  = v;
    end
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_count", 32'(words_copied), 32'd0);
    checkOutput("rst_raddr", mem_read_address, 32'd0);
    checkOutput("rst_waddr", mem_write_address, 32'd0);
    checkOutput("rst_wdata", mem_write_data, 32'd0);
    checkOutput("rst_we", 32'(mem_write_enable), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed copy, non-overlapping.
    for (int i = 0; i < 4; i++) begin
      mem[100 + i] <= 32'(i + 1);
      model[100 + i] = 32'(i + 1);
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'd100, 32'd200, 4, 32'd0, 0);
    for (int i = 0; i < 4; i++) checkOutput("copy_word", mem[200 + i], 32'(i + 1));

    // Fill, zero length, overlap.
    applyStimulus(1'b1, 32'd77, 32'd50, 3, 32'hDEADBEEF, 0);
    for (int i = 0; i < 3; i++) checkOutput("fill_word", mem[50 + i], 32'hDEADBEEF);
    applyStimulus(1'b0, 32'd5, 32'd6, 0, 32'd0, 0);
    for (int i = 0; i < 4; i++) begin
      mem[10 + i] <= 32'hA0 + 32'(i);
      model[10 + i] = 32'hA0 + 32'(i);
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'd10, 32'd11, 3, 32'd0, 0);
`ifdef MEM_DMA_BACKWARD_EN
    for (int i = 0; i < 3; i++) checkOutput("overlap_word", mem[11 + i], 32'hA0 + 32'(i));
`else
    for (int i = 0; i < 3; i++) checkOutput("overlap_word", mem[11 + i], 32'hA0);
`endif

    // Start while busy, then source wrap past 2^32.
    applyStimulus(1'b0, 32'd20, 32'd140, 6, 32'd0, 1);
    applyStimulus(1'b0, 32'hFFFF_FFFE, 32'd180, 3, 32'd0, 0);

    // Reset after two of five writes have committed.
    modelTransfer(1'b0, 32'd30, 32'd60, 5, 32'd0, 2);
    mode = 1'b0; src_addr = 32'd30; dst_addr = 32'd60; length = LW'(5);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_we", 32'(mem_write_enable), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_waddr", mem_write_address, 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_pending", 32'(exp_wr.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 32'd90, 32'd95, 1, 32'd0, 0);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] s, d;
      s = $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) s = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), s, d, $urandom_range(0, 12), $urandom, 1'($urandom_range(0, 1)));
    end

    checkOutput("left_writes", 32'(exp_wr.size()), 32'd0);
    checkOutput("left_dones", 32'(exp_done.size()), 32'd0);
    for (int i = 0; i < 256; i++) checkOutput("final_mem", mem[i], model[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
